// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, ALU-op encodings and the control bundle
// carried by every pipeline register.
package mips_pkg;

  localparam int ALU_OP_W = 2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_RSVD  = 2'b11
  } alu_op_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard equation: the instruction in ID needs a register that the
// load currently in EX has not yet produced.
module load_use_detect
  import mips_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              hz
);

  logic dest_live;
  logic rs_match;
  logic rt_match;

  // $0 is hardwired, so a load targeting it can never be a real dependency.
  assign dest_live = (ex_dest != REG_AW'(REG_ZERO));
  assign rs_match  = (ex_dest == id_rs);
  assign rt_match  = id_uses_rt & (ex_dest == id_rt);

  assign hz = id_valid & ex_valid & ex_mem_read & dest_live & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: drives register-bank selects, captures operands and
// decoded control, and turns load-use hazards or flushes into bubbles.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = ALU_OP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [31:0]        id_instr,
  input  logic [DATA_W-1:0]  id_pc4,
  input  logic               id_uses_rt,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               id_alu_src,
  input  logic               id_reg_dst,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               flush,
  output logic [REG_AW-1:0]  s_rs,
  output logic [REG_AW-1:0]  s_rt,
  input  logic [DATA_W-1:0]  rs_data,
  input  logic [DATA_W-1:0]  rt_data,
  output logic               stall,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_pc4,
  output logic [DATA_W-1:0]  ex_rs_val,
  output logic [DATA_W-1:0]  ex_rt_val,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [REG_AW-1:0]  ex_rs_num,
  output logic [REG_AW-1:0]  ex_rt_num,
  output logic [REG_AW-1:0]  ex_dest,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op
);

  logic              valid_q,  valid_d;
  logic [DATA_W-1:0] pc4_q,    pc4_d;
  logic [DATA_W-1:0] rs_val_q, rs_val_d;
  logic [DATA_W-1:0] rt_val_q, rt_val_d;
  logic [DATA_W-1:0] imm_q,    imm_d;
  logic [REG_AW-1:0] rs_num_q, rs_num_d;
  logic [REG_AW-1:0] rt_num_q, rt_num_d;
  logic [REG_AW-1:0] dest_q,   dest_d;
  ctrl_t             ctrl_q,   ctrl_d;

  logic              hz;
  logic              capture;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;

  assign id_rs = id_instr[25:21];
  assign id_rt = id_instr[20:16];
  assign id_rd = id_instr[15:11];

  assign s_rs = id_rs;
  assign s_rt = id_rt;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .id_valid    (id_valid),
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_dest     (dest_q),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .hz          (hz)
  );

  // A flushed instruction is dead, so it must not hold the PC either.
  assign stall   = hz & ~flush;
  assign capture = id_valid & ~flush & ~hz;

  always_comb begin
    valid_d  = 1'b0;
    pc4_d    = '0;
    rs_val_d = '0;
    rt_val_d = '0;
    imm_d    = '0;
    rs_num_d = '0;
    rt_num_d = '0;
    dest_d   = '0;
    ctrl_d   = CTRL_NOP;
    if (capture) begin
      valid_d           = 1'b1;
      pc4_d             = id_pc4;
      rs_val_d          = rs_data;
      rt_val_d          = rt_data;
      imm_d             = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};
      rs_num_d          = id_rs;
      rt_num_d          = id_rt;
      dest_d            = id_reg_write ? (id_reg_dst ? id_rd : id_rt) : '0;
      ctrl_d.reg_write  = id_reg_write;
      ctrl_d.mem_read   = id_mem_read;
      ctrl_d.mem_write  = id_mem_write;
      ctrl_d.mem_to_reg = id_mem_to_reg;
      ctrl_d.alu_src    = id_alu_src;
      ctrl_d.alu_op     = id_alu_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      pc4_q    <= '0;
      rs_val_q <= '0;
      rt_val_q <= '0;
      imm_q    <= '0;
      rs_num_q <= '0;
      rt_num_q <= '0;
      dest_q   <= '0;
      ctrl_q   <= CTRL_NOP;
    end else begin
      valid_q  <= valid_d;
      pc4_q    <= pc4_d;
      rs_val_q <= rs_val_d;
      rt_val_q <= rt_val_d;
      imm_q    <= imm_d;
      rs_num_q <= rs_num_d;
      rt_num_q <= rt_num_d;
      dest_q   <= dest_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc4        = pc4_q;
  assign ex_rs_val     = rs_val_q;
  assign ex_rt_val     = rt_val_q;
  assign ex_imm        = imm_q;
  assign ex_rs_num     = rs_num_q;
  assign ex_rt_num     = rt_num_q;
  assign ex_dest       = dest_q;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_alu_op     = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed pipeline scenarios followed by
// randomized traffic, all compared against a behavioural model of the stage.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_uses_rt;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
  logic [1:0]  id_alu_op;
  logic        flush;
  logic [4:0]  s_rs, s_rt;
  logic [31:0] rs_data, rt_data;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc4, ex_rs_val, ex_rt_val, ex_imm;
  logic [4:0]  ex_rs_num, ex_rt_num, ex_dest;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
  logic [1:0]  ex_alu_op;

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;

  // Expected contents of the ID/EX register.
  logic        m_valid;
  logic [31:0] m_pc4, m_rsv, m_rtv, m_imm;
  logic [4:0]  m_rsn, m_rtn, m_dest;
  logic        m_rw, m_mr, m_mw, m_m2r, m_as;
  logic [1:0]  m_op;

  localparam logic [31:0] ADD3  = 32'h0022_1820;  // add  $3,$1,$2
  localparam logic [31:0] LW4   = 32'h8C24_0000;  // lw   $4,0($1)
  localparam logic [31:0] ADD5  = 32'h0081_2820;  // add  $5,$4,$1
  localparam logic [31:0] ADDI6 = 32'h2026_FFFC;  // addi $6,$1,-4
  localparam logic [31:0] LW0   = 32'h8C20_0000;  // lw   $0,0($1)
  localparam logic [31:0] ADD0  = 32'h0000_2820;  // add  $5,$0,$0
  localparam logic [31:0] SW4   = 32'hAC24_0000;  // sw   $4,0($1)

  id_ex_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc4        (id_pc4),
    .id_uses_rt    (id_uses_rt),
    .id_reg_write  (id_reg_write),
    .id_mem_read   (id_mem_read),
    .id_mem_write  (id_mem_write),
    .id_mem_to_reg (id_mem_to_reg),
    .id_alu_src    (id_alu_src),
    .id_reg_dst    (id_reg_dst),
    .id_alu_op     (id_alu_op),
    .flush         (flush),
    .s_rs          (s_rs),
    .s_rt          (s_rt),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .stall         (stall),
    .ex_valid      (ex_valid),
    .ex_pc4        (ex_pc4),
    .ex_rs_val     (ex_rs_val),
    .ex_rt_val     (ex_rt_val),
    .ex_imm        (ex_imm),
    .ex_rs_num     (ex_rs_num),
    .ex_rt_num     (ex_rt_num),
    .ex_dest       (ex_dest),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_alu_src    (ex_alu_src),
    .ex_alu_op     (ex_alu_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_bubble();
    m_valid = 1'b0; m_pc4 = '0; m_rsv = '0; m_rtv = '0; m_imm = '0;
    m_rsn = '0; m_rtn = '0; m_dest = '0;
    m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_m2r = 1'b0; m_as = 1'b0; m_op = '0;
  endtask

  task automatic cmp_all(input string tag);
    check({tag, ".valid"},  {31'd0, ex_valid},      {31'd0, m_valid});
    check({tag, ".pc4"},    ex_pc4,                 m_pc4);
    check({tag, ".rs_val"}, ex_rs_val,              m_rsv);
    check({tag, ".rt_val"}, ex_rt_val,              m_rtv);
    check({tag, ".imm"},    ex_imm,                 m_imm);
    check({tag, ".rs_num"}, {27'd0, ex_rs_num},     {27'd0, m_rsn});
    check({tag, ".rt_num"}, {27'd0, ex_rt_num},     {27'd0, m_rtn});
    check({tag, ".dest"},   {27'd0, ex_dest},       {27'd0, m_dest});
    check({tag, ".ctrl"},
          {25'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op},
          {25'd0, m_rw, m_mr, m_mw, m_m2r, m_as, m_op});
  endtask

  task automatic set_in(input logic [31:0] instr, input bit v, input bit ut, input bit rw,
                        input bit mr, input bit mw, input bit m2r, input bit as, input bit rd,
                        input logic [1:0] op, input bit fl);
    id_instr = instr; id_valid = v; id_uses_rt = ut;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    id_alu_src = as; id_reg_dst = rd; id_alu_op = op; flush = fl;
    id_pc4 = $urandom; rs_data = $urandom; rt_data = $urandom;
  endtask

  task automatic drv_rtype(input logic [31:0] instr, input bit fl);
    set_in(instr, 1, 1, 1, 0, 0, 0, 0, 1, 2'b10, fl);
  endtask

  task automatic drv_lw(input logic [31:0] instr);
    set_in(instr, 1, 0, 1, 1, 0, 1, 1, 0, 2'b00, 0);
  endtask

  task automatic drv_sw(input logic [31:0] instr, input bit ut);
    set_in(instr, 1, ut, 0, 0, 1, 0, 1, 0, 2'b00, 0);
  endtask

  // One clock of the stage: combinational checks before the edge, full
  // register comparison after it. Reports whether the model expected a stall.
  task automatic step(input string tag, output bit stalled);
    logic [4:0] rs, rt;
    bit hz_m, take;
    #1;
    rs = id_instr[25:21];
    rt = id_instr[20:16];
    hz_m = id_valid && m_valid && m_mr && (m_dest != 5'd0) &&
           ((m_dest == rs) || (id_uses_rt && (m_dest == rt)));
    stalled = hz_m && !flush;
    take = id_valid && !flush && !hz_m;
    check({tag, ".stall"}, {31'd0, stall}, {31'd0, stalled});
    check({tag, ".s_rs"},  {27'd0, s_rs},  {27'd0, rs});
    check({tag, ".s_rt"},  {27'd0, s_rt},  {27'd0, rt});
    @(posedge clk);
    #1;
    if (!take) begin
      model_bubble();
    end else begin
      m_valid = 1'b1;
      m_pc4   = id_pc4;
      m_rsv   = rs_data;
      m_rtv   = rt_data;
      m_imm   = 32'($signed(id_instr[15:0]));
      m_rsn   = rs;
      m_rtn   = rt;
      m_dest  = !id_reg_write ? 5'd0 : (id_reg_dst ? id_instr[15:11] : rt);
      m_rw = id_reg_write; m_mr = id_mem_read; m_mw = id_mem_write;
      m_m2r = id_mem_to_reg; m_as = id_alu_src; m_op = id_alu_op;
    end
    cmp_all(tag);
    n_txn++;
    $display("txn %0d %s instr=%h v=%0b fl=%0b stall=%0b ex_valid=%0b ex_dest=%0d",
             n_txn, tag, id_instr, id_valid, flush, stall, ex_valid, ex_dest);
  endtask

  initial begin
    bit st;
    model_bubble();
    rst_n = 1'b0;
    drv_rtype(ADD3, 0);
    repeat (2) @(posedge clk);
    #1;
    cmp_all("reset_hold");
    rst_n = 1'b1;

    drv_rtype(ADD3, 0);
    rs_data = 32'h0000_ff01;
    rt_data = 32'h0000_ff02;
    step("add3", st);
    check("add3.rs_val_k", ex_rs_val, 32'h0000_ff01);
    check("add3.rt_val_k", ex_rt_val, 32'h0000_ff02);
    check("add3.dest_k", {27'd0, ex_dest}, 32'd3);

    drv_lw(LW4);            step("lw4", st);
    drv_rtype(ADD5, 0);     step("add5_stall", st);
    check("lu.stall_k", {31'd0, stall}, 32'd0);
    check("lu.bubble_k", {31'd0, ex_valid}, 32'd0);
    step("add5_go", st);
    check("lu.rs_num_k", {27'd0, ex_rs_num}, 32'd4);

    drv_lw(LW4);            step("lw4b", st);
    drv_rtype(ADD5, 1);     step("add5_flush", st);
    check("flush.bubble_k", {31'd0, ex_valid}, 32'd0);

    set_in(ADDI6, 1, 0, 1, 0, 0, 0, 1, 0, 2'b00, 0);
    step("addi6", st);
    check("addi6.imm_k", ex_imm, 32'hffff_fffc);
    check("addi6.dest_k", {27'd0, ex_dest}, 32'd6);

    drv_lw(LW0);            step("lw0", st);
    drv_rtype(ADD0, 0);     step("use0", st);

    drv_lw(LW4);            step("lw4c", st);
    drv_sw(SW4, 1);         step("sw_rt_stall", st);
    step("sw_rt_go", st);
    drv_lw(LW4);            step("lw4d", st);
    drv_sw(SW4, 0);         step("sw_nort", st);

    drv_rtype(ADD3, 0);     step("pre_rst", st);
    #3;
    rst_n = 1'b0;
    #1;
    model_bubble();
    cmp_all("async_rst");
    @(posedge clk);
    #1;
    cmp_all("rst_held");
    rst_n = 1'b1;

    st = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (st) begin
        flush = ($urandom_range(0, 9) == 0);
        rs_data = $urandom;
        rt_data = $urandom;
      end else begin
        logic [31:0] ins;
        ins = $urandom;
        ins[25:21] = 5'($urandom_range(0, 3));
        ins[20:16] = 5'($urandom_range(0, 3));
        ins[15:11] = 5'($urandom_range(0, 3));
        set_in(ins, ($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 2'($urandom), ($urandom_range(0, 9) == 0));
      end
      step("rand", st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage for the 5-stage MIPS core.
- Sits directly downstream of the 32x32 register bank. It drives the bank's read-select lines from the IF/ID instruction and captures the returned rs/rt operands.
- Also captures the sign-extended immediate, register numbers and decoder control bits into the ID/EX register.
- Performs load-use hazard detection and inserts bubbles on stall or flush.

Parameters:
DATA_W, 32, datapath/operand width
REG_AW, 5, register-number width (32 registers)
ALUOP_W, 2, width of decoder ALU-op field

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a real instruction
id_instr  in  32  instruction from IF/ID
id_pc4  in  32  PC+4 of that instruction
id_uses_rt  in  1  decoder: instruction reads rt as a source (R-type, sw, beq)
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst  in  1 each  decoder control bits
id_alu_op  in  ALUOP_W  decoder ALU op
flush  in  1  branch/jump redirect; kill the ID instruction
s_rs  out  REG_AW  to register bank = id_instr[25:21], combinational
s_rt  out  REG_AW  to register bank = id_instr[20:16], combinational
rs_data  in  DATA_W  register bank read port 1
rt_data  in  DATA_W  register bank read port 2
stall  out  1  hold PC and IF/ID this cycle, combinational
ex_valid  out  1  ID/EX holds a real instruction
ex_pc4, ex_rs_val, ex_rt_val, ex_imm  out  DATA_W each  registered operands
ex_rs_num, ex_rt_num, ex_dest  out  REG_AW each  registered register numbers
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  out  1 each  registered control
ex_alu_op  out  ALUOP_W  registered ALU op

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output is 0, including ex_valid. Outputs hold while reset is asserted. Release takes effect at the next clk edge.
- Latency: 1 cycle. Values present in ID at edge N appear on ex_* after edge N.
- Immediate: ex_imm = sign-extension of id_instr[15:0] to DATA_W.
- Destination: ex_dest = id_reg_dst ? id_instr[15:11] : id_instr[20:16]. Forced to 0 when id_reg_write=0.
- Hazard (combinational): hz = id_valid & ex_valid & ex_mem_read & (ex_dest != 0) & ((ex_dest == id_instr[25:21]) | (id_uses_rt & ex_dest == id_instr[20:16])).
- stall = hz & ~flush.
- Per-edge priority:
  1. flush=1: load bubble.
  2. Else hz=1: load bubble. Upstream holds because stall=1.
  3. Else id_valid=0: load bubble.
  4. Else capture the ID instruction, with ex_valid=1.
- Bubble: ex_valid=0; all control bits, ex_alu_op, ex_dest, ex_rs_num and ex_rt_num = 0; data fields = 0.
- A load-use stall lasts exactly 1 cycle: the bubble clears ex_mem_read, so hz deasserts the next cycle.
- The second instruction after a load is not stalled. EX-stage forwarding resolves it.
- Simultaneous flush and hazard: flush wins and stall=0. The killed instruction must not freeze the PC.
- Register 0 never triggers a hazard, even after a load to $0.
- Same-cycle bank write and read: the register bank is write-through combinational, so rs_data/rt_data are captured as presented. No internal bypass.
- s_rs/s_rt follow id_instr unconditionally, including during stall.

Decomposition:
- Shared package mips_pkg:
  - opcode/funct constants
  - ALU-op encodings
  - register-0 constant
  - packed control-bundle typedef (reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op), used by all pipeline registers
- One sub-module: load_use_detect (purely combinational hz equation). It is reused by the branch-in-ID variant later.

Test Plan:
- Reset mid-operation: pulse rst_n=0 with ex_valid=1 -> all ex_* = 0 immediately, before any clk edge.
- R-type add $3,$1,$2 (0x00221820), bank returns 0xff01/0xff02, valid -> next cycle ex_rs_val=0x0000ff01, ex_rt_val=0x0000ff02, ex_dest=3, ex_reg_write=1, stall=0.
- lw $4,0(...) then add $5,$4,$1 -> stall=1 for exactly one cycle, ex_valid=0 bubble, then add captured with ex_rs_num=4.
- Same load-use pair with flush=1 during the hazard cycle -> stall=0, bubble loaded, add discarded.
- addi $6,$1,-4 (imm 0xfffc, reg_dst=0) -> ex_imm=0xfffffffc, ex_dest=6. Following lw-to-$0 then use of $0 -> no stall.
- sw with id_uses_rt=1 matching the prior load's ex_dest on rt -> stall=1. Same encoding with id_uses_rt=0 -> stall=0.
